// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures the clk-cycle interval between rising edges of a
// slow, possibly asynchronous input. Each measurement is reported with a
// one-cycle strobe. A missing edge within TIMEOUT cycles drops lock.
module pulse_period_meter #(
    parameter int CNT_W   = 25,
    parameter int TIMEOUT = 30_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN
    } state_t;

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             sig_rise;
    logic [CNT_W-1:0] cnt, cnt_nxt, period_nxt;
    logic             pv_nxt, to_nxt, locked_nxt;

    // Two-flop synchronizer plus a history flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sig_rise = s2 & ~s3;

    // Next-state logic. An edge takes priority over an expiring count, so a
    // period of exactly TIMEOUT is still reported.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        period_nxt = period;
        pv_nxt     = 1'b0;
        to_nxt     = 1'b0;
        locked_nxt = locked;
        case (state)
            IDLE: begin
                if (sig_rise) begin
                    cnt_nxt   = ONE;
                    state_nxt = ARMED;
                end
            end
            ARMED, RUN: begin
                if (sig_rise) begin
                    period_nxt = cnt;
                    pv_nxt     = 1'b1;
                    cnt_nxt    = ONE;
                    locked_nxt = 1'b1;
                    state_nxt  = RUN;
                end else if (cnt < TMO) begin
                    cnt_nxt = cnt + ONE;
                end else begin
                    to_nxt     = 1'b1;
                    locked_nxt = 1'b0;
                    cnt_nxt    = '0;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            period       <= period_nxt;
            period_valid <= pv_nxt;
            locked       <= locked_nxt;
            timeout      <= to_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Testbench for pulse_period_meter (CNT_W=8, TIMEOUT=100), scoreboard style.
module tb_pulse_period_meter;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 100;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             timeout;

    pulse_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .reset(reset),
        .sig_in(sig_in),
        .period(period),
        .period_valid(period_valid),
        .locked(locked),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind 0 = period strobe, kind 1 = timeout strobe; at = cyc stamp when seen
    typedef struct {
        int kind;
        int val;
        int at;
    } ev_t;

    ev_t q[$];
    int  nchk = 0;
    int  nerr = 0;

    // Stimulus-side model state
    bit armed = 1'b0;
    int last_c = 0;
    int exp_period = 0;

    // Monitor-side expected lock level
    bit lock_m = 1'b0;

    task automatic chk(input string tag, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got=%0d want=%0d (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations when the DUT strobes, tracks locked.
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                lock_m = 1'b0;
            end else begin
                if (period_valid || timeout) begin
                    if (q.size() == 0) begin
                        chk("unexpected_strobe", {period_valid, timeout}, 0);
                    end else begin
                        e = q.pop_front();
                        chk("strobe_kind", {period_valid, timeout}, (e.kind == 0) ? 2'b10 : 2'b01);
                        chk("strobe_cycle", cyc, e.at);
                        chk("period", period, e.val);
                        lock_m = (e.kind == 0);
                    end
                end
                chk("locked", locked, lock_m);
            end
        end
    end

    // Rising edge on sig_in sp cycles after the previous one, held high hi cycles.
    task automatic pulse(input int sp, input int hi);
        int target;
        target = last_c + sp;
        if (armed) begin
            if (sp <= TIMEOUT) begin
                q.push_back('{kind: 0, val: sp, at: target + 3});
                exp_period = sp;
            end else begin
                q.push_back('{kind: 1, val: exp_period, at: last_c + 3 + TIMEOUT});
            end
        end
        armed = 1'b1;
        while (cyc < target) @(negedge clk);
        sig_in = 1'b1;
        last_c = cyc;
        repeat (hi) @(negedge clk);
        sig_in = 1'b0;
    endtask

    // Let any pending timeout fire, then confirm every expectation was consumed.
    task automatic drain();
        if (armed) begin
            q.push_back('{kind: 1, val: exp_period, at: last_c + 3 + TIMEOUT});
            armed = 1'b0;
        end
        while (cyc < last_c + 3 + TIMEOUT + 5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
    endtask

    task automatic do_reset(input int n, input bit toggle);
        @(negedge clk);
        reset = 1'b1;
        armed = 1'b0;
        exp_period = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_period", period, 0);
            chk("rst_valid", period_valid, 0);
            chk("rst_locked", locked, 0);
            chk("rst_timeout", timeout, 0);
            if (toggle) sig_in = ~sig_in;
        end
        reset = 1'b0;
        sig_in = 1'b0;
        @(negedge clk);
        chk("post_rst_period", period, 0);
        chk("post_rst_valid", period_valid, 0);
        chk("post_rst_locked", locked, 0);
        chk("post_rst_timeout", timeout, 0);
        last_c = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with sig_in toggling
        do_reset(3, 1'b1);

        // 2: pulses every 10 cycles
        pulse(5, 1);
        for (int i = 0; i < 4; i++) pulse(10, 1);

        // 3: spacing 7, then square wave high 1 / low 1
        for (int i = 0; i < 2; i++) pulse(7, 1);
        for (int i = 0; i < 6; i++) pulse(2, 1);

        // 4: back to 10, then stop; resume re-arms, next pulse reports spacing
        for (int i = 0; i < 2; i++) pulse(10, 1);
        pulse(150, 1);
        pulse(13, 2);

        // 5: spacing exactly TIMEOUT, then TIMEOUT+1
        pulse(100, 1);
        pulse(101, 1);
        pulse(20, 3);

        // 6: reset mid-count after lock
        pulse(10, 1);
        repeat (5) @(negedge clk);
        chk("pre_reset_queue", q.size(), 0);
        chk("pre_reset_locked", locked, 1);
        do_reset(2, 1'b0);
        pulse(5, 1);
        pulse(10, 1);
        pulse(10, 1);

        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
Receive-side counterpart of the team's clock-divider tick generators. It takes a slow, possibly asynchronous pulse or square-wave input, such as a divided tick or an external button/sensor line. It measures the number of clk cycles between successive rising edges and reports each measurement with a one-cycle valid strobe. It also flags loss of signal through a timeout. Downstream users are the display/BCD logic and the self-check harnesses for the divider blocks.

Parameters:
CNT_W, 25, width of the period counter and period output; must satisfy 2^CNT_W > TIMEOUT
TIMEOUT, 30_000_000, maximum period in clk cycles before declaring signal lost (default covers a 5 Hz tick at 100 MHz)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
sig_in  input  1  asynchronous input signal being measured
period  output  CNT_W  last measured rising-edge-to-rising-edge interval, in clk cycles
period_valid  output  1  one-cycle strobe; period updated in the same cycle
locked  output  1  high while at least one valid period has been measured and no timeout has occurred since
timeout  output  1  one-cycle strobe when no edge arrives within TIMEOUT cycles

Behaviour:
- Input conditioning: 2-flop synchronizer (s1, s2) plus a history flop s3. edge = s2 & ~s3 (combinational). sig_in rising before clk edge k gives edge high in the cycle after edge k+1.
- Reset (synchronous): s1/s2/s3 = 0; cnt = 0; state = IDLE; period = 0; period_valid = 0; locked = 0; timeout = 0.
- Strobes period_valid and timeout default to 0 every cycle unless set below.
- State IDLE (waiting for first edge):
  - On edge: cnt <= 1; go to ARMED. No period_valid.
- State ARMED (first edge seen, counting), and state RUN (locked, counting) behave identically except as noted:
  - No edge, cnt < TIMEOUT: cnt <= cnt + 1.
  - Edge, cnt <= TIMEOUT: period <= cnt; period_valid <= 1; cnt <= 1; locked <= 1; state <= RUN. An edge wins over a simultaneous timeout, so cnt == TIMEOUT with an edge reports period = TIMEOUT.
  - No edge, cnt == TIMEOUT: timeout <= 1; locked <= 0; cnt <= 0; state <= IDLE. period holds its last value.
- cnt semantics: edges detected in cycles t0 and t1 give period = t1 - t0 exactly. Minimum reportable period is 2 (sig_in high 1 cycle, low 1 cycle). Maximum is TIMEOUT.
- Latency: period_valid asserts 3 clk edges after the sig_in rising edge is first sampled. Fixed latency, so the measured value has no offset.
- A level held high produces one edge only. The block then times out.
- cnt never exceeds TIMEOUT, so there is no wrap-around.
- Reset mid-measurement discards the partial count. The first edge after reset never produces period_valid.
- locked falls only on timeout or reset. It rises together with the first period_valid.

Test Plan:
Use TIMEOUT=100 and CNT_W=8 for all sims.
1. Assert reset for 3 cycles with sig_in toggling -> period=0, period_valid=0, locked=0, timeout=0 throughout and in the first cycle after release.
2. sig_in 1-cycle-high pulses every 10 cycles -> the first edge gives no strobe. Each later edge gives a single-cycle period_valid with period=10. locked rises with the first strobe. Check the 3-cycle latency from the sig_in rise.
3. Switch the pulse spacing from 10 to 7 mid-run, then drive square wave high 1 / low 1 -> the next strobe reads 7, and the square wave gives period=2 on each edge.
4. Stop pulses after lock -> exactly 100 cycles after the last edge, timeout strobes once, locked=0, and period holds 10. A resumed pulse gives no strobe; the following pulse reports the spacing.
5. Edge exactly 100 cycles after the previous one -> period_valid with period=100 and no timeout. Edge at 101 -> timeout at cnt=100, and that edge only re-arms.
6. Reset asserted mid-count after lock, then pulses every 10 cycles -> locked=0 immediately. The first post-reset edge gives no strobe, and the second gives period=10.
